// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared state encoding and field widths for the skid-buffered pipeline stage.
package pipe_stage_skid_reg_pkg;

  localparam int OCC_W = 2;

  // Encoding doubles as the Occupancy output (number of held entries)
  typedef enum logic [OCC_W-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Upstream/downstream handshake bundle for pipe_stage_skid_reg.
interface pipe_stage_skid_reg_if #(
  parameter int NrOfBits = 32
);
  import pipe_stage_skid_reg_pkg::*;

  logic                InValid;
  logic                InReady;
  logic [NrOfBits-1:0] D;
  logic                OutValid;
  logic                OutReady;
  logic [NrOfBits-1:0] Q;
  logic [OCC_W-1:0]    Occupancy;

  // master: the surrounding pipeline; slave: the stage register itself
  modport master (
    output InValid, D, OutReady,
    input  InReady, OutValid, Q, Occupancy
  );

  modport slave (
    input  InValid, D, OutReady,
    output InReady, OutValid, Q, Occupancy
  );

endinterface

// File: rtl/pipe_data_reg.sv
// Data register with async reset, synchronous clear (dominant) and load enable.
module pipe_data_reg #(
  parameter int NrOfBits = 32
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                en,
  input  logic                clr,
  input  logic [NrOfBits-1:0] val,
  output logic [NrOfBits-1:0] q
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= val;
  end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid buffer.
// state    | meaning
// EMPTY    | nothing held, Q shows stale main data
// ONE      | main entry valid on Q
// TWO      | main and skid valid, upstream stalled
module pipe_stage_skid_reg
  import pipe_stage_skid_reg_pkg::*;
#(
  parameter int                  NrOfBits    = 32,
  parameter logic [NrOfBits-1:0] PresetValue = {NrOfBits{1'b1}},
  parameter bit                  FlushZero   = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  ClockEnable,
  input  logic                  Flush,
  input  logic                  Pre,
  pipe_stage_skid_reg_if.slave  bus
);

  state_e              state_q;
  state_e              state_d;
  logic                adv;
  logic                in_ready;
  logic                out_valid;
  logic                in_fire;
  logic                out_fire;
  logic                main_ld;
  logic                main_clr;
  logic                skid_ld;
  logic                skid_clr;
  logic [NrOfBits-1:0] main_val;
  logic [NrOfBits-1:0] main_q;
  logic [NrOfBits-1:0] skid_q;

  assign adv       = ClockEnable & Tick;
  // Ready comes straight from the state flop so OutReady never reaches InReady
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = adv & bus.InValid & in_ready;
  assign out_fire  = adv & out_valid & bus.OutReady;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    main_val = bus.D;
    if (adv) begin
      if (Flush) begin
        state_d  = ST_EMPTY;
        main_clr = FlushZero;
        skid_clr = FlushZero;
      end else if (Pre) begin
        state_d  = ST_ONE;
        main_ld  = 1'b1;
        main_val = PresetValue;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d = ST_ONE;
              main_ld = 1'b1;
            end
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              main_ld = 1'b1;
            end else if (in_fire) begin
              state_d = ST_TWO;
              skid_ld = 1'b1;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (out_fire) begin
              state_d  = ST_ONE;
              main_ld  = 1'b1;
              main_val = skid_q;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end
  end

  pipe_data_reg #(.NrOfBits(NrOfBits)) u_main (
    .Clock (Clock),
    .Reset (Reset),
    .en    (main_ld),
    .clr   (main_clr),
    .val   (main_val),
    .q     (main_q)
  );

  pipe_data_reg #(.NrOfBits(NrOfBits)) u_skid (
    .Clock (Clock),
    .Reset (Reset),
    .en    (skid_ld),
    .clr   (skid_clr),
    .val   (bus.D),
    .q     (skid_q)
  );

  assign bus.InReady   = in_ready;
  assign bus.OutValid  = out_valid;
  assign bus.Q         = main_q;
  assign bus.Occupancy = state_q;

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline-stage register that supersedes the plain enable/preset flip-flop registers between CPU stages (e.g. EX->MEM ALU result).
- Adds a valid/ready handshake with a 2-entry skid buffer, giving full throughput with a registered InReady.
- Adds synchronous flush and preset.
- Keeps the existing ClockEnable & Tick qualification so it drops into the current clock-gating scheme.

Parameters:
- NrOfBits, 32, width of D and Q.
- PresetValue, all ones (NrOfBits wide), value loaded into the main entry by Pre.
- FlushZero, 1, 1 = Flush also clears stored data to 0; 0 = Flush clears valid bits only.

Ports:
- Clock  in  1  clock; all state updates on rising edge only.
- Reset  in  1  asynchronous, active-high reset.
- Tick  in  1  global tick qualifier.
- ClockEnable  in  1  local enable; Adv = ClockEnable & Tick.
- Flush  in  1  synchronous flush, acts only when Adv=1.
- Pre  in  1  synchronous preset, acts only when Adv=1.
- InValid  in  1  upstream data valid.
- InReady  out  1  stage can accept data; registered.
- D  in  NrOfBits  upstream data.
- OutValid  out  1  Q holds valid data.
- OutReady  in  1  downstream accepts.
- Q  out  NrOfBits  main-entry data.
- Occupancy  out  2  number of held entries (0..2).

Behaviour:
- Clock and reset: clock Clock; reset Reset, asynchronous, active-high.
- On Reset: state EMPTY, main=0, skid=0. Outputs: OutValid=0, InReady=1, Q=0, Occupancy=0. This holds throughout the assertion, including mid-transfer.
- Adv=0: no state or data change. Outputs remain stable and handshakes do not fire.
- Handshake fires:
  - InFire = Adv & InValid & InReady.
  - OutFire = Adv & OutValid & OutReady.
- Output derivation:
  - InReady = (state != TWO), decoded from the state register only; no combinational path from OutReady.
  - OutValid = (state != EMPTY).
  - Q = main entry.
  - Occupancy = state encoding.
- Latency: D captured at edge k is visible on Q immediately after edge k (one cycle). Sustained throughput is 1 word/cycle when OutReady=1.
- Priority within one Adv cycle: Flush > Pre > normal handshake.
- Flush: next state EMPTY. If FlushZero=1, main and skid are set to 0; otherwise data is held. A simultaneous InFire is dropped.
- Pre (Flush=0): main=PresetValue, skid discarded, next state ONE. A simultaneous InFire is dropped.
- Normal transitions:
  - EMPTY: InFire -> ONE, main<=D. OutFire is impossible.
  - ONE:
    - InFire & OutFire -> ONE, main<=D.
    - InFire only -> TWO, skid<=D.
    - OutFire only -> EMPTY, main held.
    - Neither -> ONE.
  - TWO: OutFire -> ONE, main<=skid. InFire is impossible. Otherwise hold.
- Ordering: FIFO order is always preserved; the skid entry is never overtaken.
- Held data after drain: main keeps its last value on the transition to EMPTY, so Q shows stale data with OutValid=0.
- Illegal state encoding 2'b11 recovers to EMPTY on the next Adv.
- X on D while InFire=0 must not propagate to Q.

Decomposition:
- Shared package: state constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2; width of the Occupancy field.
- Sub-module pipe_data_reg: NrOfBits register with async Reset, load enable, load value and sync clear. Instantiated twice (main, skid); the FSM and handshake logic live in the top module.

Test Plan:
1. Reset mid-stream.
   - Stimulus: hold state TWO with OutReady=0, pulse Reset.
   - Required: OutValid=0, InReady=1, Q=0, Occupancy=0 asynchronously, before the next edge.
2. Streaming.
   - Stimulus: Adv=1, OutReady=1, InValid=1 with D=1,2,3,4 on consecutive edges.
   - Required: Q=1,2,3,4 one cycle later, InReady constant 1, Occupancy=1.
3. Backpressure.
   - Stimulus: D=0xA then 0xB with OutReady=0, then OutReady=1.
   - Required: Occupancy 1->2, InReady=0 in TWO, Q=0xA then 0xB; no loss or reorder.
4. Tick gating.
   - Stimulus: InValid=1, D=0x55, Tick=0 for 3 edges, then Tick=1.
   - Required: no capture until the Tick=1 edge; then Q=0x55, OutValid=1.
5. Flush vs Pre.
   - Stimulus: in state TWO, assert Flush=1 and Pre=1 with Adv=1.
   - Required: EMPTY, Q=0 (FlushZero=1).
   - Stimulus: next cycle Pre=1 alone.
   - Required: Q=0xFFFFFFFF, OutValid=1, Occupancy=1.
6. Simultaneous in/out in ONE.
   - Stimulus: Q=0x10, InValid=1 with D=0x20, OutReady=1.
   - Required: Q=0x20, Occupancy remains 1.
